jtag_dtm: RTL
=============

JTAG_DTM -- requirements
Module: jtag_dtm

Interface
REQ-001 Parameter ABITS, default 7, DMI address width.
REQ-002 Parameter IDLE_HINT, default 1, value reported in dtmcs.idle[14:12].
REQ-003 clk  input  1  system clock; must run at least 4x TCK.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 jtag_reset  input  1  TAP test-logic-reset indication.
REQ-006 tck, tdi, tms  input  1 each  user-chain JTAG signals, asynchronous to clk.
REQ-007 tdo  output  1  serial data out to the user chain.
REQ-008 sel_dmi  input  1  USER3 instruction selected (DMI register).
REQ-009 sel_dtmcs  input  1  USER2 instruction selected (DTMCS register).
REQ-010 dmi_req_valid  output  1; dmi_req_ready  input  1  request handshake.
REQ-011 dmi_req_addr  output  ABITS; dmi_req_data  output  32; dmi_req_op  output  2 (1 = read, 2 = write).
REQ-012 dmi_rsp_valid  input  1; dmi_rsp_ready  output  1  response handshake.
REQ-013 dmi_rsp_data  input  32; dmi_rsp_resp  input  2 (0 = ok, 2 = failed, 3 = busy).

Function
REQ-014 tck, tdi, tms, jtag_reset, sel_dmi and sel_dtmcs SHALL each pass through a 2-flop synchronizer.
- tck_rise = synced tck 0->1; tck_fall = synced tck 1->0.
- Each edge pulse is one clk wide.
REQ-015 A 16-state IEEE 1149.1 TAP tracker SHALL advance only on tck_rise, using synced tms.
- Synced jtag_reset high forces Test-Logic-Reset.
REQ-016 Capture-DR on tck_rise SHALL load the shift register:
- sel_dmi: {addr_q, data_q, status}, width ABITS+34.
- sel_dtmcs: {14'b0, dmihardreset=0, dmireset=0, 1'b0, IDLE_HINT[2:0], dmistat[1:0], ABITS[5:0], 4'd1}.
REQ-017 Shift-DR on tck_rise SHALL shift right, with tdi entering the MSB of the active width (ABITS+34 for DMI, 32 for DTMCS).
REQ-018 tdo SHALL update on tck_fall to shift[0] and hold between falls.
REQ-019 status field on DMI capture SHALL be:
- 3 while a transaction is outstanding; otherwise dmistat.
- A capture while outstanding SHALL set dmistat = 3.
REQ-020 Update-DR with sel_dmi, op in {1,2}, dmistat = 0 and no transaction outstanding SHALL:
- latch addr/data/op from the shift register;
- raise dmi_req_valid on the next clk;
- mark the transaction outstanding.
REQ-021 Update-DR with sel_dmi while outstanding SHALL set dmistat = 3 and issue nothing.
- op 0 or 3 SHALL issue nothing.
- Any update while dmistat != 0 SHALL issue nothing.
REQ-022 dmi_req_valid SHALL hold, with stable payload, until sampled with dmi_req_ready; it SHALL deassert the following clk.
REQ-023 After request acceptance, dmi_rsp_ready SHALL be 1 until dmi_rsp_valid is sampled.
- On that cycle: data_q <= dmi_rsp_data; if dmi_rsp_resp != 0, dmistat <= dmi_rsp_resp.
- outstanding clears on the next clk.
REQ-024 Response before request acceptance SHALL be ignored (dmi_rsp_ready = 0).
REQ-025 dmistat is sticky; only these SHALL change it:
- errors per REQ-019, REQ-021, REQ-023;
- clearing per REQ-026.
REQ-026 Update-DR with sel_dtmcs clears dmistat if shifted bit 16 (dmireset) or bit 17 (dmihardreset) = 1.
- dmihardreset also sets a discard flag: the pending response is consumed without updating data_q/dmistat.
- A pending request is never withdrawn.
REQ-027 Test-Logic-Reset SHALL NOT abort an outstanding DMI transaction.
REQ-028 Simultaneous tck_rise and response completion SHALL both take effect; a capture on that clk reads the pre-completion state.

Reset
REQ-029 rst_n low SHALL asynchronously force:
- TAP state Test-Logic-Reset; shift register, addr_q, data_q, op_q = 0; dmistat = 0;
- outstanding = 0; discard = 0; synchronizers = 0;
- tdo = 0, dmi_req_valid = 0, dmi_rsp_ready = 0.
REQ-030 Reset deassertion SHALL take effect on the next clk edge with no spurious tck edge; synchronizer reset value 0 avoids a false edge.

Verification
REQ-031 DTMCS read: capture with sel_dtmcs, shift 32 bits -> tdo stream = 0x00001071 (ABITS = 7, IDLE_HINT = 1), LSB first.
REQ-032 DMI write with ready stuck 0 for 5 clk:
- Stimulus: addr 0x10, data 0xDEADBEEF, op 2.
- Response: valid held 5 clk with stable payload, drops 1 clk after ready.
- After response resp 0: next capture status = 0.
REQ-033 DMI read, resp data 0x12345678 -> next capture shifts out op 0, data 0x12345678, addr 0x10.
REQ-034 Capture or second update while outstanding -> status 3, dmistat = 3, no second request.
- DTMCS write with bit 16 = 1 -> dmistat = 0.
REQ-035 dmihardreset while awaiting response:
- Later response with resp 2 -> data_q and dmistat unchanged, outstanding clears.
REQ-036 rst_n pulse mid-shift -> all outputs 0 immediately; TMS=1 for 5 TCK -> TAP state Test-Logic-Reset.

Source files
------------

// File: rtl/jtag_dtm.sv
// ---------------------------------------------------------------------------
// jtag_dtm : RISC-V style JTAG Debug Transport Module running entirely in the
// clk domain. The user-chain JTAG pins are oversampled through 2-flop
// synchronizers, a TAP tracker follows the TCK edges, and the DMI / DTMCS
// data registers are captured, shifted and updated from those edges.
//
// Ports
//   clk, rst_n                system clock (>= 4x TCK), async active-low reset
//   jtag_reset                TAP test-logic-reset indication
//   tck, tdi, tms, tdo        user-chain JTAG signals (tdo is clk-registered)
//   sel_dmi, sel_dtmcs        USER3 / USER2 instruction selected
//   dmi_req_*                 request channel (valid/ready, addr, data, op)
//   dmi_rsp_*                 response channel (valid/ready, data, resp)
//
// TAP tracker states
//   state         | meaning
//   TAP_TLR       | Test-Logic-Reset
//   TAP_RTI       | Run-Test/Idle
//   TAP_SEL_DR    | Select-DR-Scan
//   TAP_CAP_DR    | Capture-DR (data register loaded on the next rise)
//   TAP_SHIFT_DR  | Shift-DR (shift right, tdi into MSB)
//   TAP_EXIT1_DR  | Exit1-DR
//   TAP_PAUSE_DR  | Pause-DR
//   TAP_EXIT2_DR  | Exit2-DR
//   TAP_UPD_DR    | Update-DR (register acted upon on the next rise)
//   TAP_SEL_IR    | Select-IR-Scan
//   TAP_CAP_IR    | Capture-IR
//   TAP_SHIFT_IR  | Shift-IR
//   TAP_EXIT1_IR  | Exit1-IR
//   TAP_PAUSE_IR  | Pause-IR
//   TAP_EXIT2_IR  | Exit2-IR
//   TAP_UPD_IR    | Update-IR
// ---------------------------------------------------------------------------
module jtag_dtm #(
    parameter int unsigned ABITS     = 7,
    parameter int unsigned IDLE_HINT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jtag_reset,
    input  logic             tck,
    input  logic             tdi,
    input  logic             tms,
    output logic             tdo,
    input  logic             sel_dmi,
    input  logic             sel_dtmcs,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_rsp_valid,
    output logic             dmi_rsp_ready,
    input  logic [31:0]      dmi_rsp_data,
    input  logic [1:0]       dmi_rsp_resp
);

    localparam int unsigned SW      = ABITS + 34;
    localparam logic [2:0]  IDLE_F  = 3'(IDLE_HINT);
    localparam logic [5:0]  ABITS_F = 6'(ABITS);
    localparam logic [1:0]  ST_BUSY = 2'd3;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_e;

    // -----------------------------------------------------------------------
    // Synchronizers and TCK edge detection. Reset value 0 on every stage plus
    // tck_prev_q means a released reset can never fabricate a TCK edge.
    // -----------------------------------------------------------------------
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;
    logic       tck_prev_q;
    logic       tck_s, tdi_s, tms_s, jrst_s, sel_dmi_s, sel_dtmcs_s;
    logic       tck_rise, tck_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            sync1_q    <= {sel_dtmcs, sel_dmi, jtag_reset, tms, tdi, tck};
            sync2_q    <= sync1_q;
            tck_prev_q <= tck_s;
        end
    end

    assign {sel_dtmcs_s, sel_dmi_s, jrst_s, tms_s, tdi_s, tck_s} = sync2_q;
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    // -----------------------------------------------------------------------
    // TAP tracker
    // -----------------------------------------------------------------------
    tap_e tap_q, tap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= TAP_TLR;
        end else begin
            tap_q <= tap_d;
        end
    end

    always_comb begin
        tap_d = tap_q;
        if (jrst_s) begin
            tap_d = TAP_TLR;
        end else if (tck_rise) begin
            case (tap_q)
                TAP_TLR:      tap_d = tms_s ? TAP_TLR      : TAP_RTI;
                TAP_RTI:      tap_d = tms_s ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_DR:   tap_d = tms_s ? TAP_SEL_IR   : TAP_CAP_DR;
                TAP_CAP_DR:   tap_d = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_SHIFT_DR: tap_d = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_EXIT1_DR: tap_d = tms_s ? TAP_UPD_DR   : TAP_PAUSE_DR;
                TAP_PAUSE_DR: tap_d = tms_s ? TAP_EXIT2_DR : TAP_PAUSE_DR;
                TAP_EXIT2_DR: tap_d = tms_s ? TAP_UPD_DR   : TAP_SHIFT_DR;
                TAP_UPD_DR:   tap_d = tms_s ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_IR:   tap_d = tms_s ? TAP_TLR      : TAP_CAP_IR;
                TAP_CAP_IR:   tap_d = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_SHIFT_IR: tap_d = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_EXIT1_IR: tap_d = tms_s ? TAP_UPD_IR   : TAP_PAUSE_IR;
                TAP_PAUSE_IR: tap_d = tms_s ? TAP_EXIT2_IR : TAP_PAUSE_IR;
                TAP_EXIT2_IR: tap_d = tms_s ? TAP_UPD_IR   : TAP_SHIFT_IR;
                TAP_UPD_IR:   tap_d = tms_s ? TAP_SEL_DR   : TAP_RTI;
                default:      tap_d = TAP_TLR;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Data registers and DMI handshake
    // -----------------------------------------------------------------------
    logic [SW-1:0]    shift_q, shift_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       dmistat_q, dmistat_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;
    logic             req_valid_q, req_valid_d;
    logic             rsp_ready_q, rsp_ready_d;
    logic             tdo_q, tdo_d;

    logic             req_fire, rsp_fire;
    logic [1:0]       upd_op;
    logic [31:0]      dtmcs_cap;

    assign req_fire  = req_valid_q & dmi_req_ready;
    assign rsp_fire  = rsp_ready_q & dmi_rsp_valid;
    assign upd_op    = shift_q[1:0];
    assign dtmcs_cap = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_F, dmistat_q, ABITS_F, 4'd1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q       <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            op_q          <= '0;
            dmistat_q     <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            req_valid_q   <= 1'b0;
            rsp_ready_q   <= 1'b0;
            tdo_q         <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            op_q          <= op_d;
            dmistat_q     <= dmistat_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            req_valid_q   <= req_valid_d;
            rsp_ready_q   <= rsp_ready_d;
            tdo_q         <= tdo_d;
        end
    end

    always_comb begin
        shift_d       = shift_q;
        addr_d        = addr_q;
        data_d        = data_q;
        op_d          = op_q;
        dmistat_d     = dmistat_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        req_valid_d   = req_valid_q;
        rsp_ready_d   = rsp_ready_q;
        tdo_d         = tck_fall ? shift_q[0] : tdo_q;

        // Bus side first: a JTAG action on the same clk is evaluated against
        // the pre-completion register values and, when both touch dmistat,
        // the JTAG side is applied last.
        if (req_fire) begin
            req_valid_d = 1'b0;
            rsp_ready_d = 1'b1;
        end

        if (rsp_fire) begin
            rsp_ready_d   = 1'b0;
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
            if (!discard_q) begin
                data_d = dmi_rsp_data;
                if (dmi_rsp_resp != 2'd0) begin
                    dmistat_d = dmi_rsp_resp;
                end
            end
        end

        if (tck_rise && !jrst_s) begin
            case (tap_q)
                TAP_CAP_DR: begin
                    if (sel_dmi_s) begin
                        shift_d = {addr_q, data_q, outstanding_q ? ST_BUSY : dmistat_q};
                        if (outstanding_q) begin
                            dmistat_d = ST_BUSY;
                        end
                    end else if (sel_dtmcs_s) begin
                        shift_d        = '0;
                        shift_d[31:0]  = dtmcs_cap;
                    end
                end
                TAP_SHIFT_DR: begin
                    if (sel_dmi_s) begin
                        shift_d = {tdi_s, shift_q[SW-1:1]};
                    end else if (sel_dtmcs_s) begin
                        shift_d       = '0;
                        shift_d[31:0] = {tdi_s, shift_q[31:1]};
                    end
                end
                TAP_UPD_DR: begin
                    if (sel_dmi_s) begin
                        if (outstanding_q) begin
                            dmistat_d = ST_BUSY;
                        end else if (dmistat_q == 2'd0 &&
                                     (upd_op == 2'd1 || upd_op == 2'd2)) begin
                            addr_d        = shift_q[SW-1:34];
                            data_d        = shift_q[33:2];
                            op_d          = upd_op;
                            req_valid_d   = 1'b1;
                            outstanding_d = 1'b1;
                        end
                    end else if (sel_dtmcs_s) begin
                        if (shift_q[16] || shift_q[17]) begin
                            dmistat_d = 2'd0;
                        end
                        // Hard reset abandons the result of the transaction in
                        // flight; the request itself still completes on the bus.
                        if (shift_q[17] && outstanding_q && !rsp_fire) begin
                            discard_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tdo           = tdo_q;
    assign dmi_req_valid = req_valid_q;
    assign dmi_req_addr  = addr_q;
    assign dmi_req_data  = data_q;
    assign dmi_req_op    = op_q;
    assign dmi_rsp_ready = rsp_ready_q;

endmodule
